// File: rtl/apb_to_ahbl.sv
// APB slave to AHB-Lite master bridge: one single-word AHB transfer per APB access.
// Optional APB_TO_AHBL_SLVERR_EN forwards AHB error responses to pslverr.
module apb_to_ahbl #(
    parameter int                   W_PADDR    = 16,
    parameter int                   W_HADDR    = 32,
    parameter int                   W_DATA     = 32,
    parameter logic [W_HADDR-1:0]   HADDR_BASE = '0
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                apbs_psel,
    input  logic                apbs_penable,
    input  logic                apbs_pwrite,
    input  logic [W_PADDR-1:0]  apbs_paddr,
    input  logic [W_DATA-1:0]   apbs_pwdata,
    output logic                apbs_pready,
    output logic [W_DATA-1:0]   apbs_prdata,
    output logic                apbs_pslverr,

    output logic [W_HADDR-1:0]  ahblm_haddr,
    output logic                ahblm_hwrite,
    output logic [1:0]          ahblm_htrans,
    output logic [2:0]          ahblm_hsize,
    output logic [2:0]          ahblm_hburst,
    output logic [3:0]          ahblm_hprot,
    output logic                ahblm_hmastlock,
    output logic [W_DATA-1:0]   ahblm_hwdata,
    input  logic                ahblm_hready,
    input  logic                ahblm_hresp,
    input  logic [W_DATA-1:0]   ahblm_hrdata
);

    // state  | meaning
    // S_IDLE | waiting for APB setup phase
    // S_ADDR | AHB address phase, NONSEQ on htrans
    // S_DATA | AHB data phase, waiting for hready
    // S_RESP | APB completion, pready high for one cycle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]         state;
    logic [W_HADDR-1:0] haddr_q;
    logic               hwrite_q;
    logic [W_DATA-1:0]  hwdata_q;
    logic [W_DATA-1:0]  prdata_q;

`ifdef APB_TO_AHBL_SLVERR_EN
    logic               err_q;
`else
    logic               unused_hresp;
    assign unused_hresp = ahblm_hresp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            prdata_q <= '0;
`ifdef APB_TO_AHBL_SLVERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (apbs_psel && !apbs_penable) begin
                        haddr_q  <= HADDR_BASE | W_HADDR'(apbs_paddr);
                        hwrite_q <= apbs_pwrite;
                        hwdata_q <= apbs_pwdata;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ahblm_hready) state <= S_DATA;
                end
                S_DATA: begin
                    // error flag only counts on the final hready=1 cycle of a two-cycle error
                    if (ahblm_hready) begin
                        if (!hwrite_q) prdata_q <= ahblm_hrdata;
`ifdef APB_TO_AHBL_SLVERR_EN
                        err_q <= ahblm_hresp;
`endif
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign apbs_pready  = (state == S_RESP);
    assign apbs_prdata  = prdata_q;
`ifdef APB_TO_AHBL_SLVERR_EN
    assign apbs_pslverr = (state == S_RESP) && err_q;
`else
    assign apbs_pslverr = 1'b0;
`endif

    assign ahblm_haddr     = haddr_q;
    assign ahblm_hwrite    = hwrite_q;
    assign ahblm_hwdata    = hwdata_q;
    assign ahblm_htrans    = (state == S_ADDR) ? 2'b10 : 2'b00;
    assign ahblm_hsize     = 3'b010;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = 4'b0011;
    assign ahblm_hmastlock = 1'b0;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Scoreboard bench for apb_to_ahbl: APB master plus cycle-scheduled AHB slave responses.
module tb_apb_to_ahbl;

    localparam logic [31:0] HBASE = 32'h4000_0000;
`ifdef APB_TO_AHBL_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [31:0] haddr;
    logic        hwrite, hmastlock;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready, hresp;
    logic [31:0] hrdata;

    typedef struct {
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] haddr;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_prdata;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    apb_to_ahbl #(
        .W_PADDR(16), .W_HADDR(32), .W_DATA(32), .HADDR_BASE(HBASE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata),
        .apbs_pready(pready), .apbs_prdata(prdata), .apbs_pslverr(pslverr),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
        .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_htrans"}, 64'(htrans), 64'd0);
        check_val({tag, "_haddr"}, 64'(haddr), 64'd0);
        check_val({tag, "_hwrite"}, 64'(hwrite), 64'd0);
        check_val({tag, "_hwdata"}, 64'(hwdata), 64'd0);
        check_val({tag, "_pready"}, 64'(pready), 64'd0);
        check_val({tag, "_prdata"}, 64'(prdata), 64'd0);
        check_val({tag, "_pslverr"}, 64'(pslverr), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
            check_val("idle_pready", 64'(pready), 64'd0);
            check_val("idle_htrans", 64'(htrans), 64'd0);
        end
    endtask

    // aw/dw: AHB wait cycles in address/data phase; err adds a two-cycle error response
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int aw, input int dw, input logic err);
        exp_t e;
        int   dwt, lat, d;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        hready = 1'b1; hresp = 1'b0;
        check_val("setup_pready", 64'(pready), 64'd0);
        dwt = dw + (err ? 1 : 0);
        lat = 3 + aw + dwt;
        if (!wr) model_prdata = rdata;
        e.prdata = model_prdata;
        e.slverr = SLVERR_EN ? err : 1'b0;
        e.haddr  = HBASE | {16'h0, addr};
        e.lat    = lat;
        sb.push_back(e);
        for (int k = 1; k <= lat + 4; k++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            if (pready) begin
                e = sb.pop_front();
                check_val("latency", 64'(k), 64'(e.lat));
                check_val("prdata", 64'(prdata), 64'(e.prdata));
                check_val("pslverr", 64'(pslverr), 64'(e.slverr));
                check_val("resp_htrans", 64'(htrans), 64'd0);
                check_val("resp_hwdata", 64'(hwdata), 64'(wdata));
                break;
            end
            if (k >= lat) begin
                check_val("pready_timeout", 64'(pready), 64'd1);
                if (k == lat + 4) begin
                    void'(sb.pop_front());
                    break;
                end
                continue;
            end
            check_val("busy_pslverr", 64'(pslverr), 64'd0);
            check_val("haddr", 64'(haddr), 64'(sb[0].haddr));
            check_val("hwrite", 64'(hwrite), 64'(wr));
            check_val("hwdata", 64'(hwdata), 64'(wdata));
            check_val("ahb_consts", 64'({hsize, hburst, hprot, hmastlock}),
                      64'({3'b010, 3'b000, 4'b0011, 1'b0}));
            if (k <= 1 + aw) begin
                check_val("htrans_addr", 64'(htrans), 64'd2);
                hready = (k == 1 + aw);
                hresp  = 1'b0;
            end else begin
                check_val("htrans_data", 64'(htrans), 64'd0);
                d      = k - (2 + aw);
                hready = (d == dwt);
                hresp  = err && (d >= dw);
                hrdata = (d == dwt) ? rdata : 32'hFFFF_FFFF;
            end
        end
        hready = 1'b1; hresp = 1'b0;
    endtask

    task automatic mid_reset();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0020; pwdata = 32'h0;
        hready = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        check_val("mr_htrans_addr", 64'(htrans), 64'd2);
        @(posedge clk); #1;
        check_val("mr_haddr", 64'(haddr), 64'h4000_0020);
        hready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mr");
        model_prdata = 32'h0;
        psel = 1'b0; penable = 1'b0; hready = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mr_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        model_prdata = '0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_consts", 64'({hsize, hburst, hprot, hmastlock}),
                  64'({3'b010, 3'b000, 4'b0011, 1'b0}));
        rst_n = 1'b1;
        idle(2);

        xfer(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        idle(2);
        xfer(1'b1, 16'h0004, 32'h12345678, 32'h0, 0, 2, 1'b0);
        idle(1);
        xfer(1'b0, 16'h0008, 32'h0, 32'hBAD0BAD0, 0, 0, 1'b1);
        idle(1);
        xfer(1'b1, 16'h00F0, 32'hA5A5A5A5, 32'h0, 0, 0, 1'b0);
        xfer(1'b0, 16'hFFFC, 32'h0, 32'h0BADF00D, 1, 1, 1'b0);
        xfer(1'b1, 16'h0100, 32'h5A5A0001, 32'h0, 2, 0, 1'b1);
        idle(1);
        mid_reset();
        xfer(1'b0, 16'h0030, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0);
        idle(2);

        check_val("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_to_ahbl.md
APB_TO_AHBL -- requirements
Module: apb_to_ahbl

Interface
REQ-001 SHALL have parameter W_PADDR, default 16, APB address width.
REQ-002 SHALL have parameter W_HADDR, default 32, AHB-Lite address width (W_HADDR >= W_PADDR).
REQ-003 SHALL have parameter W_DATA, default 32, data width.
REQ-004 SHALL have parameter HADDR_BASE, default 0, W_HADDR-bit value ORed onto the zero-extended paddr to form haddr.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-006 apbs_psel  input  1  APB select.
REQ-007 apbs_penable  input  1  APB access phase.
REQ-008 apbs_pwrite  input  1  1 = write.
REQ-009 apbs_paddr  input  W_PADDR  APB address.
REQ-010 apbs_pwdata  input  W_DATA  APB write data.
REQ-011 apbs_pready  output  1  transfer complete.
REQ-012 apbs_prdata  output  W_DATA  read data, valid while pready=1.
REQ-013 apbs_pslverr  output  1  error, valid while pready=1.
REQ-014 ahblm_haddr / ahblm_hwrite / ahblm_htrans[1:0] / ahblm_hsize[2:0] / ahblm_hburst[2:0] / ahblm_hprot[3:0] / ahblm_hmastlock  outputs  AHB-Lite address phase.
REQ-015 ahblm_hwdata  output  W_DATA  AHB write data.
REQ-016 ahblm_hready  input  1; ahblm_hresp  input  1; ahblm_hrdata  input  W_DATA  AHB response.

Function
REQ-017 States: S_IDLE, S_ADDR (AHB address phase), S_DATA (AHB data phase), S_RESP (APB completion).
REQ-018 S_IDLE: when psel=1 and penable=0, register haddr = HADDR_BASE | paddr, hwrite = pwrite, hwdata = pwdata; go to S_ADDR.
REQ-019 S_ADDR: htrans=2'b10 (NONSEQ); stay while hready=0; on hready=1 go to S_DATA.
REQ-020 S_DATA: htrans=2'b00; hwdata held; stay while hready=0; on hready=1 capture hrdata into prdata (reads only; writes leave prdata unchanged), capture hresp into error flag, go to S_RESP.
REQ-021 Two-cycle AHB error: the first cycle (hready=0, hresp=1) is ignored; the flag is sampled only with hready=1.
REQ-022 S_RESP: pready=1 for exactly one cycle, pslverr per REQ-031; then go to S_IDLE.
REQ-023 pready=0 in every state except S_RESP; the APB master is stalled through S_ADDR and S_DATA.
REQ-024 Zero-wait-state AHB latency: setup at T0, pready=1 at T3; each AHB wait cycle adds one cycle.
REQ-025 Constant AHB outputs: hsize=3'b010 (word), hburst=3'b000, hprot=4'b0011, hmastlock=0.
REQ-026 haddr, hwrite and hwdata stay stable from S_ADDR entry until S_RESP exit.
REQ-027 Inputs are ignored outside S_IDLE. If psel drops mid-transfer (protocol violation), the AHB transfer still completes and the result is discarded.
REQ-028 A new setup phase in the cycle after S_RESP is accepted; back-to-back transfers have no extra idle cycle.

Reset
REQ-029 On rst_n=0: state=S_IDLE, htrans=0, haddr=0, hwrite=0, hwdata=0, pready=0, prdata=0, pslverr=0.
REQ-030 Reset mid-transfer abandons the transfer immediately. The AHB slave must be reset in the same domain.

Configuration
REQ-031 Macro APB_TO_AHBL_SLVERR_EN. Defined: pslverr = captured error flag in S_RESP. Undefined: pslverr is constant 0, AHB errors are dropped, and prdata on an errored read is the captured hrdata.

Verification
REQ-032 Read at paddr 0x0010, HADDR_BASE=0x40000000, zero-wait, hrdata=0xDEADBEEF -> haddr=0x40000010, htrans NONSEQ for 1 cycle, pready at T3, prdata=0xDEADBEEF, pslverr=0.
REQ-033 Write 0x12345678 to 0x0004, 2 AHB wait cycles in the data phase -> hwdata=0x12345678 stable throughout, pready at T5.
REQ-034 Read with AHB two-cycle error -> pslverr=1 with pready (macro defined); pslverr=0 (macro undefined).
REQ-035 Back-to-back write then read -> the second setup is accepted the cycle after pready; no NONSEQ is issued while busy.
REQ-036 rst_n asserted during S_DATA -> all outputs at reset values immediately; the next transfer completes normally.
